muldiv32: RTL
=============

Name: muldiv32

Overview:
- Multi-cycle multiply/divide unit for the CPU's ALU request interface.
- The control unit issues one operation with a start pulse; this block is the responder: it accepts the request, iterates, and writes the HI/LO registers.
- Complements the combinational single-cycle ALU ops (and/or/nor/add) for the MIPS mult, multu, div, divu and mthi/mtlo instructions.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits.
- ITER, 32, iteration cycles; must equal WIDTH.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request strobe, sampled only while busy=0
- op  input  2  00 mult (signed), 01 multu, 10 div (signed), 11 divu
- a  input  WIDTH  multiplicand / dividend (rs)
- b  input  WIDTH  multiplier / divisor (rt)
- hi_we  input  1  mthi write enable
- lo_we  input  1  mtlo write enable
- wdata  input  WIDTH  mthi/mtlo data
- busy  output  1  operation in progress
- done  output  1  one-cycle completion pulse
- div_zero  output  1  last completed op was a divide with b=0
- hi  output  WIDTH  HI register
- lo  output  WIDTH  LO register

Behaviour:
- Reset (rst_n=0, asynchronous, any time including mid-operation):
  - busy=0, done=0, div_zero=0, hi=0, lo=0.
  - FSM goes to IDLE; the in-flight operation is discarded.
- FSM states:
  - IDLE: start=1 at edge E0 → CALC. Latch |a|, |b| (signed ops) or raw a, b (unsigned ops). Latch the result signs. Counter=0. busy=1 after E0.
  - CALC: one step per cycle over ITER cycles (edges E1..E32); counter increments each step; after step 31 → FIX.
  - FIX (edge E33): apply sign correction, write hi/lo, set done=1 and busy=0, update div_zero, → IDLE.
- Latency: done is high during the single cycle following E33, i.e. 33 clocks after start is sampled. The result is visible on hi/lo in that same cycle. The latency is fixed for every op, including divide-by-zero.
- Multiply: shift-add on magnitudes into a 2×WIDTH product. Product sign = a[31]^b[31] for mult; the 64-bit product is two's-complement negated when the sign is set. hi = product[63:32], lo = product[31:0].
- Divide: restoring division on magnitudes.
  - Signed: quotient sign = a[31]^b[31]; remainder sign = a[31]. lo = quotient, hi = remainder.
  - Overflow case 0x80000000 / 0xFFFFFFFF (div): lo=0x80000000, hi=0. Natural wrap, no flag.
- Divide by zero (div/divu with b=0): lo=0xFFFFFFFF, hi=a unchanged, div_zero=1. Any other completed op clears div_zero.
- start while busy=1: ignored, no queueing.
- start in the done cycle: accepted, since busy=0 then.
- hi_we/lo_we:
  - Honoured only when busy=0; the write lands on the next edge.
  - If asserted together with an accepted start, the write lands at E0 and is then overwritten at E33.
  - While busy=1 they are ignored.
  - hi_we and lo_we together write wdata to both.
- hi/lo hold their values at all other times.
- op is sampled only at E0; changes to op, a or b during CALC have no effect.

Test Plan:
- Reset → busy=0, done=0, div_zero=0, hi=lo=0. multu a=0xFFFFFFFF, b=0xFFFFFFFF → done exactly 33 clocks after start; hi=0xFFFFFFFE, lo=0x00000001.
- mult a=0xFFFFFFFD (−3), b=7 → hi=0xFFFFFFFF, lo=0xFFFFFFEB. Then mult a=0x80000000, b=0x80000000 → hi=0x40000000, lo=0.
- div a=0xFFFFFFF9 (−7), b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. divu a=0xFFFFFFF9, b=2 → lo=0x7FFFFFFC, hi=1. div 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0, div_zero=0.
- divu a=100, b=0 → 33-clock latency; lo=0xFFFFFFFF, hi=100, div_zero=1. Next multu 2×3 → lo=6, hi=0, div_zero=0.
- Handshake and register writes:
  - Start divu 10/3.
  - Pulse start with op=multu at cycle 5: ignored.
  - Pulse hi_we with wdata=0xDEAD at cycle 10: ignored.
  - Final result: lo=3, hi=1.
  - Then, idle: lo_we with wdata=0x1234 → lo=0x1234 on the next edge.
  - Then start in the same cycle as a done pulse → second op accepted, its done arrives 33 clocks later.
- Start mult, drop rst_n at cycle 15 → hi=lo=0 and busy=0 immediately (asynchronous); no done pulse. After release, a fresh multu 5×5 → lo=25.

Source files
------------

// File: rtl/muldiv32.sv
// muldiv32: multi-cycle multiply/divide unit that owns the HI/LO registers.
// Multiply is shift-add, divide is restoring division; both operate on operand
// magnitudes and fix up the signs in a final cycle, so every op takes
// exactly ITER+1 clocks from the accepting edge to the write of hi/lo.
module muldiv32 #(
    parameter int WIDTH = 32,
    parameter int ITER  = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = (ITER > 1) ? $clog2(ITER) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t state_reg, state_next;

    // FSM-decoded controls
    logic accept;
    logic step_en;
    logic fix_en;
    logic reg_wr_en;

    // Iteration state: prod_reg holds {upper, lower}. For multiply upper
    // accumulates the partial product while lower shifts out multiplier bits;
    // for divide upper is the partial remainder and lower collects quotient bits.
    logic [2*WIDTH-1:0] prod_reg;
    logic [WIDTH-1:0]   b_mag_reg;
    logic [WIDTH-1:0]   a_raw_reg;
    logic [CW-1:0]      cnt_reg;
    logic               is_div_reg;
    logic               neg_q_reg;
    logic               neg_r_reg;
    logic               b_zero_reg;

    logic [WIDTH-1:0]   hi_reg;
    logic [WIDTH-1:0]   lo_reg;
    logic               done_reg;
    logic               div_zero_reg;

    // Operand conditioning at acceptance: op[0]=0 selects the signed variants
    logic               signed_op;
    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;

    assign signed_op = ~op[0];
    assign a_neg     = signed_op & a[WIDTH-1];
    assign b_neg     = signed_op & b[WIDTH-1];
    assign a_mag     = a_neg ? -a : a;
    assign b_mag     = b_neg ? -b : b;

    // One iteration step for each algorithm
    logic [WIDTH-1:0]   upper;
    logic [WIDTH-1:0]   lower;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_step;
    logic [WIDTH:0]     rem_shift;
    logic [WIDTH:0]     diff;
    logic [2*WIDTH-1:0] div_step;

    assign upper     = prod_reg[2*WIDTH-1:WIDTH];
    assign lower     = prod_reg[WIDTH-1:0];
    assign mul_sum   = {1'b0, upper} + (lower[0] ? {1'b0, b_mag_reg} : {(WIDTH+1){1'b0}});
    assign mul_step  = {mul_sum, lower[WIDTH-1:1]};
    // The partial remainder is always below the divisor, so shifting it left
    // by one fits in WIDTH+1 bits and diff's top bit is a clean borrow flag.
    assign rem_shift = {upper, lower[WIDTH-1]};
    assign diff      = rem_shift - {1'b0, b_mag_reg};
    assign div_step  = diff[WIDTH] ? {rem_shift[WIDTH-1:0], lower[WIDTH-2:0], 1'b0}
                                   : {diff[WIDTH-1:0],      lower[WIDTH-2:0], 1'b1};

    // Sign correction and final selection written to hi/lo in the FIX cycle
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;
    logic [WIDTH-1:0]   hi_fix;
    logic [WIDTH-1:0]   lo_fix;

    assign prod_fix = neg_q_reg ? -prod_reg : prod_reg;
    assign quo_fix  = neg_q_reg ? -lower : lower;
    assign rem_fix  = neg_r_reg ? -upper : upper;

    // Pick the architectural result; divide-by-zero returns all-ones / dividend
    always_comb begin
        hi_fix = prod_fix[2*WIDTH-1:WIDTH];
        lo_fix = prod_fix[WIDTH-1:0];
        if (is_div_reg) begin
            if (b_zero_reg) begin
                hi_fix = a_raw_reg;
                lo_fix = {WIDTH{1'b1}};
            end else begin
                hi_fix = rem_fix;
                lo_fix = quo_fix;
            end
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= S_IDLE;
        else        state_reg <= state_next;
    end

    // Next-state logic: IDLE -> CALC for ITER steps -> FIX -> IDLE
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:  if (start) state_next = S_CALC;
            S_CALC:  if (cnt_reg == CW'(ITER - 1)) state_next = S_FIX;
            S_FIX:   state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // FSM output decode
    always_comb begin
        busy      = (state_reg != S_IDLE);
        accept    = (state_reg == S_IDLE) && start;
        step_en   = (state_reg == S_CALC);
        fix_en    = (state_reg == S_FIX);
        reg_wr_en = (state_reg == S_IDLE);
    end

    // Operand latch at acceptance and per-cycle iteration
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prod_reg   <= '0;
            b_mag_reg  <= '0;
            a_raw_reg  <= '0;
            cnt_reg    <= '0;
            is_div_reg <= 1'b0;
            neg_q_reg  <= 1'b0;
            neg_r_reg  <= 1'b0;
            b_zero_reg <= 1'b0;
        end else if (accept) begin
            prod_reg   <= {{WIDTH{1'b0}}, a_mag};
            b_mag_reg  <= b_mag;
            a_raw_reg  <= a;
            cnt_reg    <= '0;
            is_div_reg <= op[1];
            neg_q_reg  <= a_neg ^ b_neg;
            neg_r_reg  <= a_neg;
            b_zero_reg <= (b == '0);
        end else if (step_en) begin
            prod_reg   <= is_div_reg ? div_step : mul_step;
            cnt_reg    <= cnt_reg + CW'(1);
        end
    end

    // HI/LO, done pulse and divide-by-zero flag; mthi/mtlo only while idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_reg       <= '0;
            lo_reg       <= '0;
            done_reg     <= 1'b0;
            div_zero_reg <= 1'b0;
        end else begin
            done_reg <= fix_en;
            if (fix_en) begin
                hi_reg       <= hi_fix;
                lo_reg       <= lo_fix;
                div_zero_reg <= is_div_reg & b_zero_reg;
            end else if (reg_wr_en) begin
                if (hi_we) hi_reg <= wdata;
                if (lo_we) lo_reg <= wdata;
            end
        end
    end

    assign hi       = hi_reg;
    assign lo       = lo_reg;
    assign done     = done_reg;
    assign div_zero = div_zero_reg;

endmodule
